// File: rtl/commit_sink.sv
// commit_sink: receiving end of the commit interface.
// Owns the GPR file, machine CSRs and the mcycle/minstret counters.
module commit_sink #(
    parameter int unsigned GPR_NUM   = 32,
    parameter logic [31:0] MTVEC_RST = 32'h0,
    localparam int unsigned AW = $clog2(GPR_NUM)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic          wena_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic          csr_wena_i,
    input  logic [31:0]   csr_waddr_i,
    input  logic [31:0]   csr_wdata_i,
    input  logic [AW-1:0] raddr1_i,
    output logic [31:0]   rdata1_o,
    input  logic [AW-1:0] raddr2_i,
    output logic [31:0]   rdata2_o,
    input  logic [11:0]   csr_raddr_i,
    output logic [31:0]   csr_rdata_o,
    output logic          commit_done_o
);

    typedef enum logic {IDLE = 1'b0, DONE = 1'b1} state_e;

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MCYC_L  = 12'hB00;
    localparam logic [11:0] A_MCYC_H  = 12'hB80;
    localparam logic [11:0] A_MINS_L  = 12'hB02;
    localparam logic [11:0] A_MINS_H  = 12'hB82;

    state_e state_q, state_d;

    logic [31:0] gpr_q [GPR_NUM];
    logic [31:0] mstatus_q, mtvec_q, mepc_q, mcause_q;
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;

    logic        accept;
    logic        gpr_we;
    logic [11:0] caddr;
    logic        csr_mapped;
    logic        csr_legal;
    logic        csr_we;
    logic [31:0] csr_wdata_m;
    logic [31:0] csr_rd_reg;

    assign caddr  = csr_waddr_i[11:0];
    assign gpr_we = accept && wena_i && (waddr_i != '0);

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: one accepted beat, then one DONE cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (valid_i) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        ready_o       = (state_q == IDLE);
        commit_done_o = (state_q == DONE);
        accept        = valid_i && (state_q == IDLE);
    end

    // CSR address legality and write-data masking
    always_comb begin
        csr_mapped = 1'b0;
        unique case (caddr)
            A_MSTATUS, A_MTVEC, A_MEPC, A_MCAUSE,
            A_MCYC_L, A_MCYC_H, A_MINS_L, A_MINS_H:
                csr_mapped = 1'b1;
            default: csr_mapped = 1'b0;
        endcase
        csr_legal   = csr_mapped && (csr_waddr_i[31:12] == 20'd0);
        csr_we      = accept && csr_wena_i && csr_legal;
        csr_wdata_m = csr_wdata_i;
        if (caddr == A_MTVEC || caddr == A_MEPC)
            csr_wdata_m[1:0] = 2'b00;
    end

    // GPR file; entry 0 is never written and stays zero
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < GPR_NUM; i++) gpr_q[i] <= '0;
        end else if (gpr_we) begin
            gpr_q[waddr_i] <= wdata_i;
        end
    end

    // Plain machine CSRs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mstatus_q <= 32'h0000_1800;
            mtvec_q   <= {MTVEC_RST[31:2], 2'b00};
            mepc_q    <= '0;
            mcause_q  <= '0;
        end else if (csr_we) begin
            if (caddr == A_MSTATUS) mstatus_q <= csr_wdata_m;
            if (caddr == A_MTVEC)   mtvec_q   <= csr_wdata_m;
            if (caddr == A_MEPC)    mepc_q    <= csr_wdata_m;
            if (caddr == A_MCAUSE)  mcause_q  <= csr_wdata_m;
        end
    end

    // Counter next state: a CSR write to a half replaces the increment
    always_comb begin
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q;
        if (accept) minstret_d = minstret_q + 64'd1;
        if (csr_we) begin
            unique case (caddr)
                A_MCYC_L: mcycle_d   = {mcycle_q[63:32], csr_wdata_i};
                A_MCYC_H: mcycle_d   = {csr_wdata_i, mcycle_q[31:0]};
                A_MINS_L: minstret_d = {minstret_q[63:32], csr_wdata_i};
                A_MINS_H: minstret_d = {csr_wdata_i, minstret_q[31:0]};
                default: ;
            endcase
        end
    end

    // Counter registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    // GPR read ports with same-cycle bypass of the pending beat
    always_comb begin
        rdata1_o = gpr_q[raddr1_i];
        rdata2_o = gpr_q[raddr2_i];
        if (gpr_we && waddr_i == raddr1_i) rdata1_o = wdata_i;
        if (gpr_we && waddr_i == raddr2_i) rdata2_o = wdata_i;
        if (raddr1_i == '0) rdata1_o = '0;
        if (raddr2_i == '0) rdata2_o = '0;
    end

    // CSR read port with same-cycle bypass of the pending beat
    always_comb begin
        unique case (csr_raddr_i)
            A_MSTATUS: csr_rd_reg = mstatus_q;
            A_MTVEC:   csr_rd_reg = mtvec_q;
            A_MEPC:    csr_rd_reg = mepc_q;
            A_MCAUSE:  csr_rd_reg = mcause_q;
            A_MCYC_L:  csr_rd_reg = mcycle_q[31:0];
            A_MCYC_H:  csr_rd_reg = mcycle_q[63:32];
            A_MINS_L:  csr_rd_reg = minstret_q[31:0];
            A_MINS_H:  csr_rd_reg = minstret_q[63:32];
            default:   csr_rd_reg = '0;
        endcase
        csr_rdata_o = csr_rd_reg;
        if (csr_we && caddr == csr_raddr_i) csr_rdata_o = csr_wdata_m;
    end

endmodule

// File: tb/tb_commit_sink.sv
// tb_commit_sink: directed plus randomized checks of commit_sink
// against a cycle-level behavioural model.
module tb_commit_sink;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic        wena_i = 1'b0;
    logic [4:0]  waddr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        csr_wena_i = 1'b0;
    logic [31:0] csr_waddr_i = '0;
    logic [31:0] csr_wdata_i = '0;
    logic [4:0]  raddr1_i = '0;
    logic [31:0] rdata1_o;
    logic [4:0]  raddr2_i = '0;
    logic [31:0] rdata2_o;
    logic [11:0] csr_raddr_i = '0;
    logic [31:0] csr_rdata_o;
    logic        commit_done_o;

    int checks = 0;
    int errors = 0;

    commit_sink dut (
        .clock(clock), .reset(reset),
        .valid_i(valid_i), .ready_o(ready_o),
        .wena_i(wena_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
        .csr_wena_i(csr_wena_i), .csr_waddr_i(csr_waddr_i),
        .csr_wdata_i(csr_wdata_i),
        .raddr1_i(raddr1_i), .rdata1_o(rdata1_o),
        .raddr2_i(raddr2_i), .rdata2_o(rdata2_o),
        .csr_raddr_i(csr_raddr_i), .csr_rdata_o(csr_rdata_o),
        .commit_done_o(commit_done_o)
    );

    always #5 clock = ~clock;

    // behavioural model
    logic [31:0] m_gpr [32];
    logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;
    logic [63:0] m_mcycle, m_minstret;
    bit          m_done;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_gpr[i] = '0;
        m_mstatus  = 32'h1800;
        m_mtvec    = '0;
        m_mepc     = '0;
        m_mcause   = '0;
        m_mcycle   = '0;
        m_minstret = '0;
        m_done     = 0;
    endtask

    function automatic bit legal(input logic [31:0] a);
        if (a[31:12] != 0) return 0;
        case (a[11:0])
            12'h300, 12'h305, 12'h341, 12'h342,
            12'hB00, 12'hB80, 12'hB02, 12'hB82: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] exp_gpr(input logic [4:0] ra);
        if (ra == 0) return 32'h0;
        if (!m_done && valid_i && wena_i && waddr_i == ra) return wdata_i;
        return m_gpr[ra];
    endfunction

    function automatic logic [31:0] exp_csr(input logic [11:0] ra);
        logic [31:0] w;
        if (!m_done && valid_i && csr_wena_i && legal(csr_waddr_i)
            && csr_waddr_i[11:0] == ra) begin
            w = csr_wdata_i;
            if (ra == 12'h305 || ra == 12'h341) w = w & 32'hFFFF_FFFC;
            return w;
        end
        case (ra)
            12'h300: return m_mstatus;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'hB00: return m_mcycle[31:0];
            12'hB80: return m_mcycle[63:32];
            12'hB02: return m_minstret[31:0];
            12'hB82: return m_minstret[63:32];
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // check outputs against the model, then advance one clock
    task automatic cycle();
        bit          acc;
        logic [63:0] nc, ni;
        logic [31:0] w;
        #1;
        chk("ready", {31'd0, ready_o}, {31'd0, !m_done});
        chk("done", {31'd0, commit_done_o}, {31'd0, m_done});
        chk("rdata1", rdata1_o, exp_gpr(raddr1_i));
        chk("rdata2", rdata2_o, exp_gpr(raddr2_i));
        chk("csr_rdata", csr_rdata_o, exp_csr(csr_raddr_i));
        acc = !m_done && valid_i;
        nc  = m_mcycle + 64'd1;
        ni  = m_minstret;
        w   = csr_wdata_i;
        @(posedge clock);
        if (acc) begin
            ni = ni + 64'd1;
            if (wena_i && waddr_i != 0) m_gpr[waddr_i] = wdata_i;
            if (csr_wena_i && legal(csr_waddr_i)) begin
                case (csr_waddr_i[11:0])
                    12'h300: m_mstatus = w;
                    12'h305: m_mtvec   = w & 32'hFFFF_FFFC;
                    12'h341: m_mepc    = w & 32'hFFFF_FFFC;
                    12'h342: m_mcause  = w;
                    12'hB00: nc = {m_mcycle[63:32], w};
                    12'hB80: nc = {w, m_mcycle[31:0]};
                    12'hB02: ni = {m_minstret[63:32], w};
                    12'hB82: ni = {w, m_minstret[31:0]};
                    default: ;
                endcase
            end
        end
        m_mcycle   = nc;
        m_minstret = ni;
        m_done     = acc;
        #1;
    endtask

    task automatic idle_inputs();
        valid_i    = 0;
        wena_i     = 0;
        csr_wena_i = 0;
    endtask

    // present one beat, then let the DONE cycle pass
    task automatic beat(input bit we, input logic [4:0] wa,
                        input logic [31:0] wd, input bit cwe,
                        input logic [31:0] ca, input logic [31:0] cd);
        valid_i = 1; wena_i = we; waddr_i = wa; wdata_i = wd;
        csr_wena_i = cwe; csr_waddr_i = ca; csr_wdata_i = cd;
        cycle();
        idle_inputs();
        cycle();
    endtask

    logic [31:0] caddrs [11];
    logic [11:0] craddrs [10];
    logic [31:0] mins0;
    logic        pat [4];

    initial begin
        caddrs = '{32'h300, 32'h305, 32'h341, 32'h342, 32'hB00, 32'hB80,
                   32'hB02, 32'hB82, 32'h1305, 32'h123, 32'h10300};
        craddrs = '{12'h300, 12'h305, 12'h341, 12'h342, 12'hB00,
                    12'hB80, 12'hB02, 12'hB82, 12'h344, 12'hF14};
        model_reset();

        // reset state, while reset is held
        repeat (2) @(posedge clock);
        #1;
        csr_raddr_i = 12'h300;
        #1;
        chk("rst_ready", {31'd0, ready_o}, 32'd1);
        chk("rst_done", {31'd0, commit_done_o}, 32'd0);
        chk("rst_mstatus", csr_rdata_o, 32'h1800);
        @(posedge clock);
        #1;
        reset = 1;
        model_reset();

        // sweep all GPRs
        for (int i = 0; i < 32; i++) begin
            raddr1_i = i[4:0];
            raddr2_i = 5'(31 - i);
            cycle();
        end

        // GPR write with same-cycle bypass
        raddr1_i = 5; csr_raddr_i = 12'hB02;
        valid_i = 1; wena_i = 1; waddr_i = 5; wdata_i = 32'hDEADBEEF;
        #1;
        chk("byp_x5", rdata1_o, 32'hDEADBEEF);
        cycle();
        idle_inputs();
        #1;
        chk("done_pulse", {31'd0, commit_done_o}, 32'd1);
        chk("arr_x5", rdata1_o, 32'hDEADBEEF);
        chk("minstret1", csr_rdata_o, 32'd1);
        cycle();
        cycle();

        // x0 guard
        raddr1_i = 0;
        valid_i = 1; wena_i = 1; waddr_i = 0; wdata_i = 32'hFFFFFFFF;
        #1;
        chk("x0_byp", rdata1_o, 32'h0);
        cycle();
        idle_inputs();
        cycle();
        chk("x0_arr", rdata1_o, 32'h0);
        chk("minstret2", csr_rdata_o, 32'd2);

        // CSR masking and illegal address
        csr_raddr_i = 12'h305;
        beat(0, 0, 0, 1, 32'h305, 32'h80000003);
        cycle();
        chk("mtvec_mask", csr_rdata_o, 32'h80000000);
        beat(0, 0, 0, 1, 32'h1305, 32'h12345678);
        cycle();
        chk("mtvec_hi_addr", csr_rdata_o, 32'h80000000);

        // back-to-back: valid held four cycles
        csr_raddr_i = 12'hB02;
        #1;
        mins0 = csr_rdata_o;
        valid_i = 1; wena_i = 1; waddr_i = 9;
        for (int i = 0; i < 4; i++) begin
            wdata_i = 32'h100 + i;
            #1;
            pat[i] = commit_done_o;
            cycle();
        end
        idle_inputs();
        cycle();
        chk("b2b_pat", {28'd0, pat[0], pat[1], pat[2], pat[3]}, 32'b0101);
        chk("b2b_mins", csr_rdata_o, mins0 + 32'd2);
        raddr1_i = 9;
        cycle();
        chk("b2b_x9", rdata1_o, 32'h102);

        // minstret write and wrap
        beat(0, 0, 0, 1, 32'hB02, 32'hFFFFFFFF);
        beat(0, 0, 0, 1, 32'hB82, 32'hFFFFFFFF);
        beat(0, 0, 0, 0, 0, 0);
        csr_raddr_i = 12'hB02;
        cycle();
        chk("wrap_lo", csr_rdata_o, 32'h0);
        csr_raddr_i = 12'hB82;
        cycle();
        chk("wrap_hi", csr_rdata_o, 32'h0);

        // simultaneous GPR and CSR write
        raddr2_i = 12; csr_raddr_i = 12'h342;
        beat(1, 12, 32'hCAFEF00D, 1, 32'h342, 32'h8000000B);
        cycle();
        chk("dual_gpr", rdata2_o, 32'hCAFEF00D);
        chk("dual_csr", csr_rdata_o, 32'h8000000B);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            valid_i     = ($urandom_range(0, 9) < 7);
            wena_i      = $urandom_range(0, 1);
            waddr_i     = 5'($urandom);
            wdata_i     = $urandom;
            csr_wena_i  = ($urandom_range(0, 9) < 3);
            csr_waddr_i = caddrs[$urandom_range(0, 10)];
            csr_wdata_i = $urandom;
            raddr1_i    = ($urandom_range(0, 3) == 0) ? waddr_i : 5'($urandom);
            raddr2_i    = 5'($urandom);
            csr_raddr_i = ($urandom_range(0, 3) == 0)
                        ? csr_waddr_i[11:0] : craddrs[$urandom_range(0, 9)];
            cycle();
        end
        idle_inputs();
        cycle();

        // reset asserted during DONE
        raddr1_i = 7;
        valid_i = 1; wena_i = 1; waddr_i = 7; wdata_i = 32'h1234;
        cycle();
        idle_inputs();
        reset = 0;
        #1;
        chk("rst_mid_done", {31'd0, commit_done_o}, 32'd0);
        chk("rst_mid_ready", {31'd0, ready_o}, 32'd1);
        chk("rst_mid_x7", rdata1_o, 32'h0);
        model_reset();
        @(posedge clock);
        #1;
        reset = 1;
        csr_raddr_i = 12'hB02;
        cycle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
